// File: rtl/reservation_station_if.sv
// Decoded-operation type plus the station's dispatch / CDB / issue bundle.
// The station takes the slave side; dispatch, CDB and exec drive the master side.
package reservation_station_pkg;
  typedef enum logic [3:0] {
    UNKNOWN = 4'd0,
    ADD     = 4'd1,
    SUB     = 4'd2,
    MUL     = 4'd3,
    LOAD    = 4'd4,
    STORE   = 4'd5,
    BRANCH  = 4'd6
  } instr_name_e;
endpackage

interface reservation_station_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic                               flush;
  logic                               in_valid;
  logic                               in_ready;
  logic [XLEN-1:0]                    in_data_1;
  logic [XLEN-1:0]                    in_data_2;
  logic                               in_rdy_1;
  logic                               in_rdy_2;
  logic [5:0]                         in_tag_1;
  logic [5:0]                         in_tag_2;
  logic [XLEN-1:0]                    in_address;
  logic [XLEN-1:0]                    in_immediate;
  logic [5:0]                         in_rrn;
  reservation_station_pkg::instr_name_e in_instr_name;
  logic                               cdb_valid;
  logic [5:0]                         cdb_rrn;
  logic [XLEN-1:0]                    cdb_result;
  logic                               out_valid;
  logic                               out_ready;
  logic [XLEN-1:0]                    data_1;
  logic [XLEN-1:0]                    data_2;
  logic [XLEN-1:0]                    address;
  logic [XLEN-1:0]                    immediate;
  logic [5:0]                         rrn;
  reservation_station_pkg::instr_name_e instr_name;
  logic [CW-1:0]                      count;

  modport master (
    output flush, in_valid, in_data_1, in_data_2, in_rdy_1, in_rdy_2, in_tag_1, in_tag_2,
           in_address, in_immediate, in_rrn, in_instr_name, cdb_valid, cdb_rrn, cdb_result,
           out_ready,
    input  in_ready, out_valid, data_1, data_2, address, immediate, rrn, instr_name, count
  );

  modport slave (
    input  flush, in_valid, in_data_1, in_data_2, in_rdy_1, in_rdy_2, in_tag_1, in_tag_2,
           in_address, in_immediate, in_rrn, in_instr_name, cdb_valid, cdb_rrn, cdb_result,
           out_ready,
    output in_ready, out_valid, data_1, data_2, address, immediate, rrn, instr_name, count
  );
endinterface

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: CDB operand capture, oldest-ready issue into
// a one-deep output register; accepted instructions issue no earlier than the next edge.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  reset,
  reservation_station_if.slave rs
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic            busy;
    logic [XLEN-1:0] data_1;
    logic            rdy_1;
    logic [5:0]      tag_1;
    logic [XLEN-1:0] data_2;
    logic            rdy_2;
    logic [5:0]      tag_2;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] immediate;
    logic [5:0]      rrn;
    instr_name_e     instr_name;
  } entry_t;

  entry_t        ent   [DEPTH];
  entry_t        ent_n [DEPTH];
  entry_t        new_ent;
  logic [CW-1:0] count_q;
  logic [CW-1:0] ins_idx;
  logic [SW-1:0] sel;
  logic          found;
  logic          issue;
  logic          accept;

  assign rs.in_ready = (count_q < CW'(DEPTH));
  assign rs.count    = count_q;
  assign accept      = rs.in_valid & rs.in_ready;

  // Scan downward so the lowest ready index wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent[i].busy && ent[i].rdy_1 && ent[i].rdy_2) begin
        found = 1'b1;
        sel   = SW'(i);
      end
    end
    issue = found && (!rs.out_valid || rs.out_ready);
  end

  always_comb begin
    new_ent            = '0;
    new_ent.busy       = 1'b1;
    new_ent.data_1     = rs.in_data_1;
    new_ent.rdy_1      = rs.in_rdy_1;
    new_ent.tag_1      = rs.in_tag_1;
    new_ent.data_2     = rs.in_data_2;
    new_ent.rdy_2      = rs.in_rdy_2;
    new_ent.tag_2      = rs.in_tag_2;
    new_ent.address    = rs.in_address;
    new_ent.immediate  = rs.in_immediate;
    new_ent.rrn        = rs.in_rrn;
    new_ent.instr_name = rs.in_instr_name;
    if (!rs.in_rdy_1 && rs.cdb_valid && rs.cdb_rrn == rs.in_tag_1) begin
      new_ent.data_1 = rs.cdb_result;
      new_ent.rdy_1  = 1'b1;
    end
    if (!rs.in_rdy_2 && rs.cdb_valid && rs.cdb_rrn == rs.in_tag_2) begin
      new_ent.data_2 = rs.cdb_result;
      new_ent.rdy_2  = 1'b1;
    end
  end

  // Collapse, then wake up survivors, then drop the new entry into the first free slot.
  always_comb begin
    ins_idx = count_q - CW'(issue);
    for (int i = 0; i < DEPTH; i++) ent_n[i] = ent[i];
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel)) ent_n[i] = ent[i+1];
      end
      ent_n[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_n[i].busy && rs.cdb_valid) begin
        if (!ent_n[i].rdy_1 && ent_n[i].tag_1 == rs.cdb_rrn) begin
          ent_n[i].data_1 = rs.cdb_result;
          ent_n[i].rdy_1  = 1'b1;
        end
        if (!ent_n[i].rdy_2 && ent_n[i].tag_2 == rs.cdb_rrn) begin
          ent_n[i].data_2 = rs.cdb_result;
          ent_n[i].rdy_2  = 1'b1;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && CW'(i) == ins_idx) ent_n[i] = new_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || rs.flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count_q       <= '0;
      rs.out_valid  <= 1'b0;
      rs.data_1     <= '0;
      rs.data_2     <= '0;
      rs.address    <= '0;
      rs.immediate  <= '0;
      rs.rrn        <= '0;
      rs.instr_name <= UNKNOWN;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_n[i];
      count_q <= count_q + CW'(accept) - CW'(issue);
      if (issue) begin
        rs.out_valid  <= 1'b1;
        rs.data_1     <= ent[sel].data_1;
        rs.data_2     <= ent[sel].data_2;
        rs.address    <= ent[sel].address;
        rs.immediate  <= ent[sel].immediate;
        rs.rrn        <= ent[sel].rrn;
        rs.instr_name <= ent[sel].instr_name;
      end else if (rs.out_ready) begin
        rs.out_valid  <= 1'b0;
        rs.data_1     <= '0;
        rs.data_2     <= '0;
        rs.address    <= '0;
        rs.immediate  <= '0;
        rs.rrn        <= '0;
        rs.instr_name <= UNKNOWN;
      end
    end
  end
endmodule
